// File: rtl/calc_sequencer.sv
// ============================================================================
//  Module      : calc_sequencer
//  Description : Operand/opcode entry sequencer with ALU launch and watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_sequencer #(
    parameter int SIZE    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enter,
    input  logic              clear,
    input  logic [SIZE-1:0]   sw,
    input  logic [1:0]        op_in,
    input  logic              alu_done,
    input  logic [2*SIZE-1:0] alu_result,
    output logic [SIZE-1:0]   opnd_a,
    output logic [SIZE-1:0]   opnd_b,
    output logic [1:0]        op,
    output logic              alu_start,
    output logic [2*SIZE-1:0] result,
    output logic              err,
    output logic              busy,
    output logic              mux_sel,
    output logic [2:0]        state
);

    localparam logic [2:0] c_GET_A  = 3'd0;
    localparam logic [2:0] c_GET_B  = 3'd1;
    localparam logic [2:0] c_GET_OP = 3'd2;
    localparam logic [2:0] c_RUN    = 3'd3;
    localparam logic [2:0] c_WAIT   = 3'd4;
    localparam logic [2:0] c_SHOW   = 3'd5;

    localparam int             CW        = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  c_CNT_MAX = CW'(TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [SIZE-1:0]   r_opnd_a;
    logic [SIZE-1:0]   r_opnd_b;
    logic [1:0]        r_op;
    logic [2*SIZE-1:0] r_result;
    logic              r_err;
    logic [CW-1:0]     r_cnt;
    logic              w_expired;
    logic              w_mux_sel;
    logic              w_busy;
    logic              w_alu_start;

    assign w_expired = (r_cnt == c_CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_GET_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = c_GET_A;
        end else begin
            case (r_state)
                c_GET_A:  if (enter) w_next_state = c_GET_B;
                c_GET_B:  if (enter) w_next_state = c_GET_OP;
                c_GET_OP: if (enter) w_next_state = c_RUN;
                c_RUN:    w_next_state = c_WAIT;
                c_WAIT:   if (alu_done || w_expired) w_next_state = c_SHOW;
                c_SHOW:   if (enter) w_next_state = c_GET_A;
                default:  w_next_state = c_GET_A;
            endcase
        end
    end

    always_comb begin
        w_mux_sel   = 1'b0;
        w_busy      = 1'b0;
        w_alu_start = 1'b0;
        case (r_state)
            c_GET_A: w_mux_sel = 1'b1;
            c_RUN: begin
                w_busy      = 1'b1;
                w_alu_start = 1'b1;
            end
            c_WAIT:  w_busy = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers; completion in the expiry cycle beats the timeout.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_opnd_a <= '0;
            r_opnd_b <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                c_GET_A:  if (enter) r_opnd_a <= sw;
                c_GET_B:  if (enter) r_opnd_b <= sw;
                c_GET_OP: if (enter) r_op <= op_in;
                c_RUN:    r_cnt <= '0;
                c_WAIT: begin
                    if (alu_done) begin
                        r_result <= alu_result;
                        r_err    <= 1'b0;
                    end else if (w_expired) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign opnd_a    = r_opnd_a;
    assign opnd_b    = r_opnd_b;
    assign op        = r_op;
    assign result    = r_result;
    assign err       = r_err;
    assign state     = r_state;
    assign mux_sel   = w_mux_sel;
    assign busy      = w_busy;
    assign alu_start = w_alu_start;

endmodule

`default_nettype wire

// File: tb/tb_calc_sequencer.sv
// ============================================================================
//  Module      : tb_calc_sequencer
//  Description : Scoreboard-based self-checking bench for calc_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_sequencer;

    localparam int SIZE    = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              enter;
    logic              clear;
    logic [SIZE-1:0]   sw;
    logic [1:0]        op_in;
    logic              alu_done;
    logic [2*SIZE-1:0] alu_result;
    logic [SIZE-1:0]   opnd_a;
    logic [SIZE-1:0]   opnd_b;
    logic [1:0]        op;
    logic              alu_start;
    logic [2*SIZE-1:0] result;
    logic              err;
    logic              busy;
    logic              mux_sel;
    logic [2:0]        state;

    typedef struct packed {
        logic [2*SIZE-1:0] res;
        logic              err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    calc_sequencer #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .enter      (enter),
        .clear      (clear),
        .sw         (sw),
        .op_in      (op_in),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .opnd_a     (opnd_a),
        .opnd_b     (opnd_b),
        .op         (op),
        .alu_start  (alu_start),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .mux_sel    (mux_sel),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [SIZE-1:0] s, input logic [1:0] o);
        sw    = s;
        op_in = o;
        enter = 1'b1;
        tick();
        enter = 1'b0;
        sw    = SIZE'($urandom);
        op_in = 2'($urandom);
    endtask

    task automatic load(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic [1:0] o);
        press(a, 2'd0);
        press(b, 2'd0);
        press(4'd0, o);
    endtask

    // ALU model: starting in the RUN cycle (k=0), pulses done at cycle k=delay.
    task automatic run_alu(input int delay, input logic [2*SIZE-1:0] val,
                           input bit spam_enter,
                           output int cycles, output int starts, output int nbusy);
        int k;
        k      = 0;
        starts = 0;
        nbusy  = 0;
        while (state != 3'd5 && k < 100) begin
            if (alu_start) starts++;
            if (busy) nbusy++;
            enter      = spam_enter;
            alu_done   = (k == delay);
            alu_result = (k == delay) ? val : 8'($urandom);
            tick();
            k++;
        end
        enter    = 1'b0;
        alu_done = 1'b0;
        cycles   = k;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        enter      = 1'b1;
        clear      = 1'b0;
        sw         = 4'hF;
        op_in      = 2'd3;
        alu_done   = 1'b1;
        alu_result = 8'hFF;
        tick();
        tick();
        rst      = 1'b0;
        enter    = 1'b0;
        alu_done = 1'b0;
        checks++;
        if (state !== 3'd0 || mux_sel !== 1'b1 || busy !== 1'b0 || alu_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: state=%0d mux_sel=%b busy=%b alu_start=%b, required 0/1/0/0",
                     state, mux_sel, busy, alu_start);
        end
        checks++;
        if (opnd_a !== 4'h0 || opnd_b !== 4'h0 || op !== 2'd0 || result !== 8'h00 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: a=%h b=%h op=%0d result=%h err=%b, required all zero",
                     opnd_a, opnd_b, op, result, err);
        end
    endtask

    task automatic test_capture_and_run();
        int cyc, st, nb;
        exp_t e;
        press(4'hA, 2'd0);
        checks++;
        if (state !== 3'd1 || opnd_a !== 4'hA || mux_sel !== 1'b0) begin
            errors++;
            $display("FAIL capture_a: state=%0d a=%h mux_sel=%b, required 1/A/0", state, opnd_a, mux_sel);
        end
        press(4'h3, 2'd0);
        checks++;
        if (state !== 3'd2 || opnd_b !== 4'h3 || mux_sel !== 1'b0) begin
            errors++;
            $display("FAIL capture_b: state=%0d b=%h mux_sel=%b, required 2/3/0", state, opnd_b, mux_sel);
        end
        sb.push_back('{res: 8'h1E, err: 1'b0});
        press(4'h0, 2'd2);
        checks++;
        if (state !== 3'd3 || op !== 2'd2 || alu_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL run_entry: state=%0d op=%0d alu_start=%b busy=%b, required 3/2/1/1",
                     state, op, alu_start, busy);
        end
        run_alu(3, 8'h1E, 1'b0, cyc, st, nb);
        checks++;
        if (cyc !== 4 || st !== 1 || nb !== 4) begin
            errors++;
            $display("FAIL normal_timing: cycles=%0d starts=%0d busy=%0d, required 4/1/4", cyc, st, nb);
        end
        e = (sb.size() != 0) ? sb.pop_front() : '{res: 8'hXX, err: 1'bx};
        checks++;
        if (result !== e.res || err !== e.err || state !== 3'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL normal_result: result=%h err=%b state=%0d busy=%b, required %h/%b/5/0",
                     result, err, state, busy, e.res, e.err);
        end
        tick();
        checks++;
        if (state !== 3'd5 || result !== 8'h1E) begin
            errors++;
            $display("FAIL show_hold: state=%0d result=%h, required 5/1e", state, result);
        end
        press(4'h0, 2'd0);
        checks++;
        if (state !== 3'd0 || mux_sel !== 1'b1 || opnd_a !== 4'hA || opnd_b !== 4'h3 || op !== 2'd2) begin
            errors++;
            $display("FAIL show_exit: state=%0d mux_sel=%b a=%h b=%h op=%0d, required 0/1/A/3/2",
                     state, mux_sel, opnd_a, opnd_b, op);
        end
    endtask

    task automatic test_timeout();
        int cyc, st, nb;
        exp_t e;
        load(4'h5, 4'h6, 2'd1);
        sb.push_back('{res: 8'h00, err: 1'b1});
        run_alu(-1, 8'h00, 1'b0, cyc, st, nb);
        checks++;
        if (cyc !== TIMEOUT + 1 || st !== 1 || nb !== TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_timing: cycles=%0d starts=%0d busy=%0d, required %0d/1/%0d",
                     cyc, st, nb, TIMEOUT + 1, TIMEOUT + 1);
        end
        e = (sb.size() != 0) ? sb.pop_front() : '{res: 8'hXX, err: 1'bx};
        checks++;
        if (result !== e.res || err !== e.err || state !== 3'd5) begin
            errors++;
            $display("FAIL timeout_result: result=%h err=%b state=%0d, required %h/%b/5",
                     result, err, state, e.res, e.err);
        end
        press(4'h0, 2'd0);
    endtask

    task automatic test_done_at_expiry();
        int cyc, st, nb;
        exp_t e;
        load(4'h7, 4'h9, 2'd3);
        sb.push_back('{res: 8'hC3, err: 1'b0});
        run_alu(TIMEOUT, 8'hC3, 1'b0, cyc, st, nb);
        e = (sb.size() != 0) ? sb.pop_front() : '{res: 8'hXX, err: 1'bx};
        checks++;
        if (cyc !== TIMEOUT + 1 || result !== e.res || err !== e.err || state !== 3'd5) begin
            errors++;
            $display("FAIL expiry_done: cycles=%0d result=%h err=%b state=%0d, required %0d/%h/%b/5",
                     cyc, result, err, state, TIMEOUT + 1, e.res, e.err);
        end
        press(4'h0, 2'd0);
    endtask

    task automatic test_ignored_inputs();
        int cyc, st, nb;
        exp_t e;
        load(4'h1, 4'h2, 2'd0);
        sb.push_back('{res: 8'h00, err: 1'b1});
        run_alu(0, 8'h55, 1'b1, cyc, st, nb);
        e = (sb.size() != 0) ? sb.pop_front() : '{res: 8'hXX, err: 1'bx};
        checks++;
        if (cyc !== TIMEOUT + 1 || st !== 1 || result !== e.res || err !== e.err) begin
            errors++;
            $display("FAIL ignore_run_wait: cycles=%0d starts=%0d result=%h err=%b, required %0d/1/%h/%b",
                     cyc, st, result, err, TIMEOUT + 1, e.res, e.err);
        end
        press(4'h0, 2'd0);
        press(4'h4, 2'd0);
        sw    = 4'hF;
        clear = 1'b1;
        enter = 1'b1;
        tick();
        clear = 1'b0;
        enter = 1'b0;
        checks++;
        if (state !== 3'd0 || opnd_b !== 4'h0 || opnd_a !== 4'h0) begin
            errors++;
            $display("FAIL clear_beats_enter: state=%0d a=%h b=%h, required 0/0/0", state, opnd_a, opnd_b);
        end
    endtask

    task automatic test_clear_in_wait();
        int starts;
        int bad_state;
        load(4'hA, 4'hB, 2'd1);
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear      = 1'b0;
        alu_done   = 1'b1;
        alu_result = 8'hEE;
        tick();
        alu_done = 1'b0;
        checks++;
        if (state !== 3'd0 || opnd_a !== 4'h0 || opnd_b !== 4'h0 || op !== 2'd0 ||
            result !== 8'h00 || err !== 1'b0) begin
            errors++;
            $display("FAIL clear_wait: state=%0d a=%h b=%h op=%0d result=%h err=%b, required 0 and all zero",
                     state, opnd_a, opnd_b, op, result, err);
        end
        starts    = 0;
        bad_state = 0;
        for (int i = 0; i < 20; i++) begin
            if (alu_start) starts++;
            if (state !== 3'd0 || result !== 8'h00) bad_state++;
            tick();
        end
        checks++;
        if (starts !== 0 || bad_state !== 0) begin
            errors++;
            $display("FAIL clear_quiet: starts=%0d off_cycles=%0d, required 0/0", starts, bad_state);
        end
    endtask

    initial begin
        test_reset();
        test_capture_and_run();
        test_timeout();
        test_done_at_expiry();
        test_ignored_inputs();
        test_clear_in_wait();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
